// File: rtl/block_grid_renderer.sv
// Occupancy-grid block renderer: row-coloured cells drawn onto the VGA
// pixel stream, with sequenced clear, acked row writes and a level tick.
module block_grid_renderer #(
  parameter int GRID_ROWS = 8,
  parameter int GRID_COLS = 8,
  parameter int CELL_W = 80,
  parameter int CELL_H = 60,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  parameter int unsigned BASE_PERIOD = 2**22,
  parameter int unsigned PERIOD_STEP = 2**18,
  parameter int unsigned MIN_PERIOD = 2**16
) (
  input  logic clk,
  input  logic reset,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic in_display,
  input  logic wr_en,
  input  logic [((GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1)-1:0] wr_row,
  input  logic [GRID_COLS-1:0] wr_bits,
  input  logic [COLOR_W-1:0] wr_color,
  output logic wr_ack,
  input  logic clr,
  output logic busy,
  output logic clr_done,
  input  logic [3:0] level,
  input  logic tick_en,
  output logic tick,
  output logic [COLOR_W-1:0] rgb
);

  localparam int RW =
    (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int CXW =
    (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int unsigned BIG =
    (BASE_PERIOD > PERIOD_STEP) ?
    BASE_PERIOD : PERIOD_STEP;
  localparam int PW = $clog2(BIG + 1) + 5;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [RW-1:0] idx;
  logic wr_ok;
  logic clr_row;
  logic clr_last;

  logic [GRID_COLS-1:0] rows [GRID_ROWS];
  logic [COLOR_W-1:0] colors [GRID_ROWS];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (clr) state_nxt = CLEAR;
      CLEAR: if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    wr_ok = 1'b0;
    clr_row = 1'b0;
    clr_last = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ok = wr_en && !clr &&
          (int'(wr_row) < GRID_ROWS);
      end
      CLEAR: begin
        busy = 1'b1;
        clr_row = 1'b1;
        clr_last = (int'(idx) == GRID_ROWS - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      wr_ack <= 1'b0;
      clr_done <= 1'b0;
      for (int i = 0; i < GRID_ROWS; i++) begin
        rows[i] <= '0;
        colors[i] <= '0;
      end
    end else begin
      wr_ack <= wr_ok;
      clr_done <= clr_row && clr_last;
      if (clr_row && !clr_last) idx <= idx + RW'(1);
      else idx <= '0;
      if (wr_ok) begin
        rows[wr_row] <= wr_bits;
        colors[wr_row] <= wr_color;
      end
      if (clr_row) begin
        rows[idx] <= '0;
        colors[idx] <= '0;
      end
    end
  end

  logic [9:0] cx;
  logic [9:0] cy;
  logic de;

  always_ff @(posedge clk) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
      de <= 1'b0;
    end else begin
      cx <= counter_x / 10'(CELL_W);
      cy <= counter_y / 10'(CELL_H);
      de <= in_display;
    end
  end

  // Row 0 is the bottom band, so flip the cell row index.
  logic in_grid;
  logic [RW-1:0] ri;
  logic [CXW-1:0] ci;
  logic [COLOR_W-1:0] px;

  always_comb begin
    in_grid = de &&
      (int'(cx) < GRID_COLS) &&
      (int'(cy) < GRID_ROWS);
    ri = RW'(GRID_ROWS - 1) - cy[RW-1:0];
    ci = cx[CXW-1:0];
    px = '0;
    if (in_grid) begin
      px = rows[ri][ci] ? colors[ri] : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rgb <= '0;
    else rgb <= px;
  end

  logic [PW-1:0] red;
  logic [PW-1:0] raw;
  logic [PW-1:0] period;
  logic [PW-1:0] cnt;
  logic fire;

  always_comb begin
    red = PW'(level) * PW'(PERIOD_STEP);
    if (red >= PW'(BASE_PERIOD)) raw = '0;
    else raw = PW'(BASE_PERIOD) - red;
    if (raw < PW'(MIN_PERIOD)) period = PW'(MIN_PERIOD);
    else period = raw;
    fire = (cnt >= period - PW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset || !tick_en) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (fire) begin
      cnt <= '0;
      tick <= 1'b1;
    end else begin
      cnt <= cnt + PW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_grid_renderer.sv
// Randomised self-checking bench for block_grid_renderer against a
// cell-level grid model and tick interval expectations.
module tb_block_grid_renderer;

  localparam logic [7:0] BG = 8'h25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [9:0] counter_x;
  logic [9:0] counter_y;
  logic in_display;
  logic wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_bits;
  logic [7:0] wr_color;
  logic wr_ack;
  logic clr;
  logic busy;
  logic clr_done;
  logic [3:0] level;
  logic tick_en;
  logic tick;
  logic [7:0] rgb;

  logic wr_en6;
  logic [2:0] wr_row6;
  logic [7:0] wr_bits6;
  logic [7:0] wr_color6;
  logic wr_ack6;
  logic clr6;
  logic busy6;
  logic clr_done6;
  logic tick_en6;
  logic tick6;
  logic [7:0] rgb6;

  block_grid_renderer #(
    .BG_COLOR(BG),
    .BASE_PERIOD(100),
    .PERIOD_STEP(10),
    .MIN_PERIOD(30)
  ) dut (
    .clk(clk), .reset(reset),
    .counter_x(counter_x), .counter_y(counter_y),
    .in_display(in_display),
    .wr_en(wr_en), .wr_row(wr_row),
    .wr_bits(wr_bits), .wr_color(wr_color),
    .wr_ack(wr_ack), .clr(clr), .busy(busy),
    .clr_done(clr_done), .level(level),
    .tick_en(tick_en), .tick(tick), .rgb(rgb)
  );

  block_grid_renderer #(
    .GRID_ROWS(6),
    .CELL_H(80),
    .BASE_PERIOD(100),
    .PERIOD_STEP(10),
    .MIN_PERIOD(30)
  ) dut6 (
    .clk(clk), .reset(reset),
    .counter_x(counter_x), .counter_y(counter_y),
    .in_display(in_display),
    .wr_en(wr_en6), .wr_row(wr_row6),
    .wr_bits(wr_bits6), .wr_color(wr_color6),
    .wr_ack(wr_ack6), .clr(clr6), .busy(busy6),
    .clr_done(clr_done6), .level(level),
    .tick_en(tick_en6), .tick(tick6), .rgb(rgb6)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] mrow [8];
  logic [7:0] mcol [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      mrow[i] = '0;
      mcol[i] = '0;
    end
  endfunction

  function automatic logic [7:0] exp_px(
    int x, int y, bit d);
    int c;
    int r;
    c = x / 80;
    r = y / 60;
    if (!d || c >= 8 || r >= 8) return 8'h00;
    return mrow[7-r][c] ? mcol[7-r] : BG;
  endfunction

  function automatic int per(int l);
    int p;
    p = 100 - 10 * l;
    return (p < 30) ? 30 : p;
  endfunction

  task automatic px_get(input int x, input int y,
    input bit d, output logic [7:0] g,
    output logic [7:0] g6);
    counter_x = 10'(x);
    counter_y = 10'(y);
    in_display = d;
    step();
    step();
    g = rgb;
    g6 = rgb6;
  endtask

  task automatic do_write(input int r,
    input logic [7:0] b, input logic [7:0] c,
    output logic ack);
    wr_en = 1'b1;
    wr_row = 3'(r);
    wr_bits = b;
    wr_color = c;
    step();
    wr_en = 1'b0;
    ack = wr_ack;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    counter_x = '0; counter_y = '0;
    in_display = 1'b0;
    wr_en = 1'b0; wr_row = '0;
    wr_bits = '0; wr_color = '0;
    clr = 1'b0; level = '0; tick_en = 1'b0;
    wr_en6 = 1'b0; wr_row6 = '0;
    wr_bits6 = '0; wr_color6 = '0;
    clr6 = 1'b0; tick_en6 = 1'b0;
    repeat (3) step();
    total++;
    if (rgb !== 8'h00) begin
      bad++; $display("FAIL rst_rgb got=%h want=00", rgb);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (wr_ack !== 1'b0) begin
      bad++; $display("FAIL rst_ack got=%b want=0", wr_ack);
    end
    total++;
    if (clr_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_done got=%b want=0", clr_done);
    end
    total++;
    if (tick !== 1'b0) begin
      bad++; $display("FAIL rst_tick got=%b want=0", tick);
    end
    reset = 1'b0;
    model_clear();
    step();
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] g, g6, e;
    int xs[3] = '{0, 80, 560};
    int ys[3] = '{479, 479, 420};
    do_write(0, 8'h81, 8'hE0, ack);
    mrow[0] = 8'h81; mcol[0] = 8'hE0;
    total++;
    if (ack !== 1'b1) begin
      bad++; $display("FAIL wr_ack got=%b want=1", ack);
    end
    step();
    total++;
    if (wr_ack !== 1'b0) begin
      bad++; $display("FAIL wr_ack_pulse got=%b want=0", wr_ack);
    end
    for (int i = 0; i < 3; i++) begin
      px_get(xs[i], ys[i], 1'b1, g, g6);
      e = exp_px(xs[i], ys[i], 1'b1);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL wr_px(%0d,%0d) got=%h want=%h",
          xs[i], ys[i], g, e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      int r;
      logic [7:0] b, c;
      r = $urandom_range(0, 7);
      b = 8'($urandom);
      c = 8'($urandom);
      do_write(r, b, c, ack);
      mrow[r] = b; mcol[r] = c;
      total++;
      if (ack !== 1'b1) begin
        bad++; $display("FAIL rnd_ack%0d got=%b want=1", i, ack);
      end
    end
    for (int i = 0; i < 24; i++) begin
      int x, y;
      bit d;
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      d = ($urandom_range(0, 3) != 0);
      px_get(x, y, d, g, g6);
      e = exp_px(x, y, d);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rnd_px(%0d,%0d,%0d) got=%h want=%h",
          x, y, d, g, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic ack;
    logic [7:0] g, g6;
    for (int r = 0; r < 8; r++) begin
      do_write(r, 8'hFF, 8'h3C, ack);
      mrow[r] = 8'hFF; mcol[r] = 8'h3C;
    end
    px_get(0, 479, 1'b0, g, g6);
    total++;
    if (g !== 8'h00) begin
      bad++; $display("FAIL oor_de0 got=%h want=00", g);
    end
    px_get(640, 479, 1'b1, g, g6);
    total++;
    if (g !== 8'h00) begin
      bad++; $display("FAIL oor_x640 got=%h want=00", g);
    end
    px_get(0, 480, 1'b1, g, g6);
    total++;
    if (g !== 8'h00) begin
      bad++; $display("FAIL oor_y480 got=%h want=00", g);
    end
    px_get(639, 0, 1'b1, g, g6);
    total++;
    if (g !== 8'h3C) begin
      bad++; $display("FAIL oor_edge got=%h want=3c", g);
    end
    for (int r = 6; r < 8; r++) begin
      wr_en6 = 1'b1; wr_row6 = 3'(r);
      wr_bits6 = 8'hFF; wr_color6 = 8'h77;
      step();
      wr_en6 = 1'b0;
      total++;
      if (wr_ack6 !== 1'b0) begin
        bad++;
        $display("FAIL oor_row%0d_ack got=%b want=0", r, wr_ack6);
      end
    end
    wr_en6 = 1'b1; wr_row6 = 3'd5;
    wr_bits6 = 8'h01; wr_color6 = 8'h42;
    step();
    wr_en6 = 1'b0;
    total++;
    if (wr_ack6 !== 1'b1) begin
      bad++; $display("FAIL r6_row5_ack got=%b want=1", wr_ack6);
    end
    px_get(0, 0, 1'b1, g, g6);
    total++;
    if (g6 !== 8'h42) begin
      bad++; $display("FAIL r6_top got=%h want=42", g6);
    end
    px_get(0, 479, 1'b1, g, g6);
    total++;
    if (g6 !== 8'h00) begin
      bad++; $display("FAIL r6_row0 got=%h want=00", g6);
    end
    px_get(0, 480, 1'b1, g, g6);
    total++;
    if (g6 !== 8'h00) begin
      bad++; $display("FAIL r6_y480 got=%h want=00", g6);
    end
    total++;
    if ({busy6, clr_done6, tick6} !== 3'b000) begin
      bad++;
      $display("FAIL r6_idle got=%b want=000",
        {busy6, clr_done6, tick6});
    end
  endtask

  task automatic test_reset_mid_clear();
    logic ack;
    logic [7:0] g, g6;
    int dones;
    do_write(3, 8'hFF, 8'h1C, ack);
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rmc_busy got=%b want=1", busy);
    end
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rmc_busy0 got=%b want=0", busy);
    end
    total++;
    if (rgb !== 8'h00) begin
      bad++; $display("FAIL rmc_rgb got=%h want=00", rgb);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (clr_done || busy) dones++;
      step();
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL rmc_nodone got=%0d want=0", dones);
    end
    px_get(40, 240, 1'b1, g, g6);
    total++;
    if (g !== exp_px(40, 240, 1'b1)) begin
      bad++;
      $display("FAIL rmc_row3 got=%h want=%h",
        g, exp_px(40, 240, 1'b1));
    end
    px_get(600, 479, 1'b1, g, g6);
    total++;
    if (g !== exp_px(600, 479, 1'b1)) begin
      bad++;
      $display("FAIL rmc_row0 got=%h want=%h",
        g, exp_px(600, 479, 1'b1));
    end
  endtask

  task automatic test_clear();
    logic ack;
    logic [7:0] g, g6, e;
    int nbusy, ndone, done_i, nack;
    for (int r = 0; r < 8; r++) begin
      do_write(r, 8'hFF, 8'h1C, ack);
      mrow[r] = 8'hFF; mcol[r] = 8'h1C;
      total++;
      if (ack !== 1'b1) begin
        bad++; $display("FAIL fill_ack%0d got=%b want=1", r, ack);
      end
    end
    px_get(400, 300, 1'b1, g, g6);
    total++;
    if (g !== 8'h1C) begin
      bad++; $display("FAIL fill_px got=%h want=1c", g);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    nbusy = 0; ndone = 0; done_i = -1; nack = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy) nbusy++;
      if (clr_done) begin
        ndone++; done_i = i;
      end
      if (wr_ack) nack++;
      wr_en = (i == 3);
      wr_row = 3'd0;
      wr_bits = 8'hFF;
      wr_color = 8'h03;
      step();
    end
    wr_en = 1'b0;
    model_clear();
    total++;
    if (nbusy != 8) begin
      bad++; $display("FAIL clr_busy got=%0d want=8", nbusy);
    end
    total++;
    if (ndone != 1 || done_i != 8) begin
      bad++;
      $display("FAIL clr_done got=%0d@%0d want=1@8",
        ndone, done_i);
    end
    total++;
    if (nack != 0) begin
      bad++; $display("FAIL clr_ack got=%0d want=0", nack);
    end
    for (int r = 0; r < 8; r++) begin
      int x, y;
      x = $urandom_range(0, 639);
      y = (7 - r) * 60 + $urandom_range(0, 59);
      px_get(x, y, 1'b1, g, g6);
      e = exp_px(x, y, 1'b1);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL clr_px_r%0d got=%h want=%h", r, g, e);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] g, g6;
    bit seen;
    wr_en = 1'b1; clr = 1'b1;
    wr_row = 3'd4; wr_bits = 8'hAA; wr_color = 8'h55;
    step();
    wr_en = 1'b0; clr = 1'b0;
    total++;
    if (wr_ack !== 1'b0) begin
      bad++; $display("FAIL col_ack got=%b want=0", wr_ack);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL col_busy got=%b want=1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (clr_done) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL col_done got=0 want=1");
    end
    px_get(80, 180, 1'b1, g, g6);
    total++;
    if (g !== exp_px(80, 180, 1'b1)) begin
      bad++;
      $display("FAIL col_row4 got=%h want=%h",
        g, exp_px(80, 180, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, g6, e;
    for (int r = 1; r < 5; r++) begin
      logic [7:0] b, c;
      b = 8'($urandom);
      c = 8'($urandom);
      wr_en = 1'b1; wr_row = 3'(r);
      wr_bits = b; wr_color = c;
      mrow[r] = b; mcol[r] = c;
      step();
      total++;
      if (wr_ack !== 1'b1) begin
        bad++; $display("FAIL b2b_ack%0d got=%b want=1", r, wr_ack);
      end
    end
    wr_en = 1'b0;
    step();
    total++;
    if (wr_ack !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%b want=0", wr_ack);
    end
    for (int r = 1; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        px_get(c * 80 + 5, (7 - r) * 60 + 7, 1'b1, g, g6);
        e = exp_px(c * 80 + 5, (7 - r) * 60 + 7, 1'b1);
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL b2b_px r%0d c%0d got=%h want=%h",
            r, c, g, e);
        end
      end
    end
  endtask

  task automatic test_tick();
    int q[$];
    int p;
    tick_en = 1'b0;
    level = 4'd0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick) q.push_back(k);
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL tick_off got=%0d want=0", q.size());
    end
    q.delete();
    tick_en = 1'b1;
    for (int k = 1; k <= 350; k++) begin
      step();
      if (tick) q.push_back(k);
    end
    p = per(0);
    total++;
    if (q.size() != 3 || q[0] != p ||
        q[1] != 2 * p || q[2] != 3 * p) begin
      bad++;
      $display("FAIL tick_l0 got=%0d ticks first=%0d want=3 first=%0d",
        q.size(), (q.size() > 0) ? q[0] : -1, p);
    end
    tick_en = 1'b0;
    step();
    q.delete();
    level = 4'd9;
    tick_en = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (tick) q.push_back(k);
    end
    p = per(9);
    total++;
    if (q.size() != 4 || q[0] != p || q[3] != 4 * p) begin
      bad++;
      $display("FAIL tick_l9 got=%0d ticks first=%0d want=4 first=%0d",
        q.size(), (q.size() > 0) ? q[0] : -1, p);
    end
    tick_en = 1'b0;
    step();
    q.delete();
    level = 4'd0;
    tick_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick) q.push_back(k);
      if (k == 70) level = 4'd5;
    end
    p = per(5);
    total++;
    if (q.size() != 3 || q[0] != 71 ||
        q[1] != 71 + p || q[2] != 71 + 2 * p) begin
      bad++;
      $display("FAIL tick_raise got=%0d ticks first=%0d want=3 first=71",
        q.size(), (q.size() > 0) ? q[0] : -1);
    end
    tick_en = 1'b0;
    q.delete();
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick) q.push_back(k);
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL tick_hold got=%0d want=0", q.size());
    end
    tick_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (tick) q.push_back(k);
    end
    total++;
    if (q.size() != 1 || q[0] != p) begin
      bad++;
      $display("FAIL tick_restart got=%0d first=%0d want=1 first=%0d",
        q.size(), (q.size() > 0) ? q[0] : -1, p);
    end
    tick_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_reset_mid_clear();
    test_clear();
    test_collision();
    test_back_to_back();
    test_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

endmodule
